// File: rtl/dino_pkg.sv
// Shared Dino game types and geometry, also used by the VGA controller.
package dino_pkg;

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } dino_state_t;

  localparam int GROUND_LINE = 335;
  localparam int DINO_W      = 60;
  localparam int DINO_H      = 60;
  localparam int GROUND_Y    = GROUND_LINE - DINO_H;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous button, with a registered rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic s1, s2, s2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      s2_d <= s2;
      rise <= s2 & ~s2_d;
    end
  end

  assign level = s2;

endmodule

// File: rtl/dino_motion.sv
// Per-frame dinosaur jump/fall engine; updates sprite y once per frame on the frame tick.
module dino_motion #(
  parameter int GROUND_Y  = dino_pkg::GROUND_Y,
  parameter int DINO_X    = 50,
  parameter int JUMP_V    = 16,
  parameter int GRAVITY   = 1,
  parameter int FAST_FALL = 3,
  parameter int MAX_FALL  = 20,
  parameter int TOP_Y     = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        up,
  input  logic        down,
  input  logic        game_on,
  input  logic        game_over,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic        ducking
);

  import dino_pkg::*;

  dino_state_t state, state_n;
  logic [9:0]  y, y_n;
  logic [5:0]  vy, vy_n;
  logic        jump_req;
  logic        ft_q, tick;
  logic        up_rise, down_s;
  logic        up_level_unused, down_rise_unused;
  logic        up_ok, req_eff;
  int          g, yn, vn;

  btn_sync u_up_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (up),
    .level (up_level_unused),
    .rise  (up_rise)
  );

  btn_sync u_down_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (down),
    .level (down_s),
    .rise  (down_rise_unused)
  );

  // An edge arriving in the same cycle as the tick launches on that tick.
  assign up_ok   = up_rise && (state == GROUND) && game_on && !game_over;
  assign req_eff = jump_req || up_ok;

  // Signed int math stands in for the 11-bit signed intermediates; y never leaves [TOP_Y, GROUND_Y].
  always_comb begin
    state_n = state;
    y_n     = y;
    vy_n    = vy;
    yn      = 0;
    vn      = 0;
    g       = down_s ? FAST_FALL : GRAVITY;
    if (tick && !game_over) begin
      case (state)
        GROUND: begin
          if (req_eff) begin
            y_n = 10'(GROUND_Y - JUMP_V);
            if (JUMP_V - g <= 0) begin
              state_n = FALL;
              vy_n    = '0;
            end else begin
              state_n = RISE;
              vy_n    = 6'(JUMP_V - g);
            end
          end
        end
        RISE: begin
          yn = int'(y) - int'(vy);
          if (yn < TOP_Y) begin
            y_n     = 10'(TOP_Y);
            vy_n    = '0;
            state_n = FALL;
          end else begin
            y_n = 10'(yn);
            if (int'(vy) <= g) begin
              vy_n    = '0;
              state_n = FALL;
            end else begin
              vy_n = 6'(int'(vy) - g);
            end
          end
        end
        FALL: begin
          vn = int'(vy) + g;
          if (vn > MAX_FALL) vn = MAX_FALL;
          if (int'(y) + vn >= GROUND_Y) begin
            y_n     = 10'(GROUND_Y);
            vy_n    = '0;
            state_n = GROUND;
          end else begin
            y_n  = 10'(int'(y) + vn);
            vy_n = 6'(vn);
          end
        end
        default: state_n = GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= GROUND;
      y        <= 10'(GROUND_Y);
      vy       <= '0;
      jump_req <= 1'b0;
      ft_q     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      ft_q  <= frame_tick;
      tick  <= frame_tick & ~ft_q;
      state <= state_n;
      y     <= y_n;
      vy    <= vy_n;
      if (game_over || tick) jump_req <= 1'b0;
      else if (up_ok)        jump_req <= 1'b1;
    end
  end

  assign dino_x   = 32'(DINO_X);
  assign dino_y   = {22'd0, y};
  assign airborne = (state != GROUND);
  assign ducking  = (state == GROUND) && down_s;

endmodule

// File: tb/tb_dino_motion.sv
// Scoreboarded frame-by-frame check of dino_motion trajectories and gating.
module tb_dino_motion;

  logic        clk = 1'b0;
  logic        reset, frame_tick, up, down, game_on, game_over;
  logic [31:0] x_a, y_a, x_b, y_b;
  logic        air_a, duck_a, air_b, duck_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  dino_motion dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
    .game_on(game_on), .game_over(game_over),
    .dino_x(x_a), .dino_y(y_a), .airborne(air_a), .ducking(duck_a)
  );

  dino_motion #(.JUMP_V(30)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
    .game_on(game_on), .game_over(game_over),
    .dino_x(x_b), .dino_y(y_b), .airborne(air_b), .ducking(duck_b)
  );

  typedef struct {
    int    y;
    bit    air;
    bit    sel_b;
    string tag;
  } exp_t;

  typedef struct {
    bit up_p;
    bit dn;
    int y;
    bit air;
  } vec_t;

  exp_t sb[$];
  vec_t nj[33];
  vec_t ff[12];
  int   ceil_y[11] = '{245, 216, 188, 161, 135, 110, 86, 63, 41, 40, 41};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_frame(input int y, input bit air, input bit sel_b, input string tag);
    exp_t e;
    e.y = y; e.air = air; e.sel_b = sel_b; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel_b) begin
        check({e.tag, " y"}, y_b, e.y);
        check({e.tag, " air"}, {31'd0, air_b}, {31'd0, e.air});
      end else begin
        check({e.tag, " y"}, y_a, e.y);
        check({e.tag, " air"}, {31'd0, air_a}, {31'd0, e.air});
      end
    end
  endtask

  // frame_tick is held 4 clk like screenEnd; outputs settle 2 clk after its rise.
  task automatic frame();
    @(negedge clk) frame_tick = 1'b1;
    repeat (4) @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    drain();
  endtask

  task automatic press_up();
    @(negedge clk) up = 1'b1;
    repeat (4) @(negedge clk);
    up = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int j;
    for (int k = 1; k <= 32; k++) begin
      nj[k-1].up_p = (k == 1) || (k == 5) || (k == 20);
      nj[k-1].dn   = 1'b0;
      if (k <= 16) nj[k-1].y = 275 - (k * (33 - k)) / 2;
      else begin
        j = k - 16;
        nj[k-1].y = 139 + (j * (j + 1)) / 2;
      end
      nj[k-1].air = (k < 32);
    end
    nj[32] = '{up_p: 1'b0, dn: 1'b0, y: 275, air: 1'b0};

    ff[0]  = '{1'b1, 1'b1, 259, 1'b1};
    ff[1]  = '{1'b0, 1'b1, 246, 1'b1};
    ff[2]  = '{1'b0, 1'b1, 236, 1'b1};
    ff[3]  = '{1'b0, 1'b1, 229, 1'b1};
    ff[4]  = '{1'b0, 1'b1, 225, 1'b1};
    ff[5]  = '{1'b0, 1'b1, 224, 1'b1};
    ff[6]  = '{1'b0, 1'b1, 227, 1'b1};
    ff[7]  = '{1'b0, 1'b1, 233, 1'b1};
    ff[8]  = '{1'b0, 1'b1, 242, 1'b1};
    ff[9]  = '{1'b0, 1'b1, 254, 1'b1};
    ff[10] = '{1'b0, 1'b1, 269, 1'b1};
    ff[11] = '{1'b0, 1'b1, 275, 1'b0};

    reset = 1'b1; frame_tick = 1'b0; up = 1'b0; down = 1'b0;
    game_on = 1'b0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("rst dino_x", x_a, 32'd50);
    check("rst dino_y", y_a, 32'd275);
    check("rst airborne", {31'd0, air_a}, 32'd0);
    check("rst ducking", {31'd0, duck_a}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Starting press with game_on low must not jump, nor leave a stale request.
    press_up();
    expect_frame(275, 1'b0, 1'b0, "game_off press");
    frame();
    game_on = 1'b1;
    expect_frame(275, 1'b0, 1'b0, "game_on no stale");
    frame();

    // Ceiling clamp on the JUMP_V=30 instance.
    do_reset();
    press_up();
    for (int k = 0; k < 11; k++) begin
      expect_frame(ceil_y[k], 1'b1, 1'b1, $sformatf("ceil %0d", k));
      frame();
    end

    do_reset();
    for (int k = 0; k < 33; k++) begin
      down = nj[k].dn;
      if (nj[k].up_p) press_up();
      expect_frame(nj[k].y, nj[k].air, 1'b0, $sformatf("jump %0d", k + 1));
      frame();
    end

    down = 1'b1;
    repeat (3) @(negedge clk);
    check("ducking ground", {31'd0, duck_a}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      down = ff[k].dn;
      if (ff[k].up_p) press_up();
      expect_frame(ff[k].y, ff[k].air, 1'b0, $sformatf("fastfall %0d", k + 1));
      frame();
      if (k == 2) check("ducking air", {31'd0, duck_a}, 32'd0);
    end
    down = 1'b0;
    repeat (3) @(negedge clk);

    // Edge and tick in the same cycle: edge launches on that tick.
    @(negedge clk) up = 1'b1;
    @(negedge clk);
    @(negedge clk) frame_tick = 1'b1;
    expect_frame(259, 1'b1, 1'b0, "coincident up");
    repeat (4) @(negedge clk);
    frame_tick = 1'b0;
    up = 1'b0;
    repeat (4) @(negedge clk);
    drain();
    for (int k = 0; k < 4; k++) begin
      expect_frame(nj[k+1].y, 1'b1, 1'b0, $sformatf("pre-reset %0d", k + 2));
      frame();
    end

    @(negedge clk) reset = 1'b1;
    #1;
    check("async rst y", y_a, 32'd275);
    check("async rst air", {31'd0, air_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_frame(275, 1'b0, 1'b0, "after rst");
    frame();

    // Pending request must be dropped by game_over.
    press_up();
    game_over = 1'b1;
    expect_frame(275, 1'b0, 1'b0, "over with req");
    frame();
    game_over = 1'b0;
    expect_frame(275, 1'b0, 1'b0, "req cleared");
    frame();

    press_up();
    for (int k = 0; k < 24; k++) begin
      expect_frame(nj[k].y, 1'b1, 1'b0, $sformatf("pre-freeze %0d", k + 1));
      frame();
    end
    game_over = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expect_frame(175, 1'b1, 1'b0, $sformatf("freeze %0d", k));
      frame();
    end
    game_over = 1'b0;
    expect_frame(184, 1'b1, 1'b0, "thaw");
    frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
